// File: rtl/adder_nbit_pipelined_pkg.sv
// Shared types and helpers for the pipelined N-bit ripple adder.
// Holds the overflow-mode encodings, the slice-width helper and the per-stage control payload.
package adder_pkg;

    localparam logic OVF_UNSIGNED = 1'b0;
    localparam logic OVF_SIGNED   = 1'b1;

    // Control side of one stage; the slice sums live in per-stage data vectors.
    typedef struct packed {
        logic valid;
        logic mode;
        logic carry;
        logic cim;
    } stage_ctrl_t;

    function automatic int slice_w(input int bits, input int stages);
        return bits / stages;
    endfunction

endpackage

// File: rtl/adder_nbit_pipelined_if.sv
// Operand/result stream bundle for the pipelined adder.
// The master side is the producer and consumer pair; the slave side is the adder itself.
interface adder_nbit_pipelined_if #(
    parameter int NUM_BITS = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [NUM_BITS-1:0] a;
    logic [NUM_BITS-1:0] b;
    logic                carry_in;
    logic                signed_mode;
    logic                out_valid;
    logic                out_ready;
    logic [NUM_BITS-1:0] sum;
    logic                overflow;

    modport master (
        output in_valid, a, b, carry_in, signed_mode, out_ready,
        input  in_ready, out_valid, sum, overflow
    );

    modport slave (
        input  in_valid, a, b, carry_in, signed_mode, out_ready,
        output in_ready, out_valid, sum, overflow
    );
endinterface

// File: rtl/adder_nbit_pipelined_fa.sv
// One-bit full adder, the building block of every ripple slice.
module adder_full_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    logic w_p;

    assign w_p = i_a ^ i_b;
    assign o_s = w_p ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & w_p);
endmodule

// File: rtl/adder_nbit_pipelined_slice.sv
// Combinational SLICE-bit ripple adder built from full adders.
// Also exposes the carry into its top bit for two's-complement overflow.
module adder_slice_ripple #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic             i_cin,
    output logic [SLICE-1:0] o_sum,
    output logic             o_cout,
    output logic             o_cim
);
    logic [SLICE:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        adder_full_bit u_fa (
            .i_a (i_a[i]),
            .i_b (i_b[i]),
            .i_c (w_c[i]),
            .o_s (o_sum[i]),
            .o_c (w_c[i+1])
        );
    end

    assign o_cout = w_c[SLICE];
    assign o_cim  = w_c[SLICE-1];
endmodule

// File: rtl/adder_nbit_pipelined.sv
// Pipelined N-bit ripple adder: one slice per stage, carry registered between stages,
// global stall when the output is held, result NUM_STAGES cycles after acceptance.
module adder_nbit_pipelined
    import adder_pkg::*;
#(
    parameter int NUM_BITS   = 16,
    parameter int NUM_STAGES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    adder_nbit_pipelined_if.slave bus
);
    localparam int SLICE = slice_w(NUM_BITS, NUM_STAGES);
    localparam int LAST  = NUM_STAGES - 1;

    function automatic logic ovf_flag(input logic mode, input logic cout, input logic cim);
        return (mode == OVF_SIGNED) ? (cout ^ cim) : cout;
    endfunction

    logic                  w_en;
    logic [NUM_BITS-1:0]   w_a   [NUM_STAGES];
    logic [NUM_BITS-1:0]   w_b   [NUM_STAGES];
    logic [NUM_BITS-1:0]   w_sum [NUM_STAGES];
    logic [SLICE-1:0]      w_ssum[NUM_STAGES];
    logic [NUM_STAGES-1:0] w_cin;
    logic [NUM_STAGES-1:0] w_mode;
    logic [NUM_STAGES-1:0] w_vld;
    logic [NUM_STAGES-1:0] w_cout;
    logic [NUM_STAGES-1:0] w_cim;
    logic                  w_unused_ok;

    // Operand vectors double as skew registers (upper slices not yet added) and
    // sum vectors as deskew registers (lower slices already completed).
    logic [NUM_BITS-1:0]   r_a   [NUM_STAGES];
    logic [NUM_BITS-1:0]   r_b   [NUM_STAGES];
    logic [NUM_BITS-1:0]   r_sum [NUM_STAGES];
    stage_ctrl_t           r_ctl [NUM_STAGES];

    assign w_en         = !r_ctl[LAST].valid || bus.out_ready;
    assign bus.in_ready = w_en;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_a[k]    = bus.a;
            assign w_b[k]    = bus.b;
            assign w_sum[k]  = '0;
            assign w_cin[k]  = bus.carry_in;
            assign w_mode[k] = bus.signed_mode;
            assign w_vld[k]  = bus.in_valid;
        end else begin : g_body
            assign w_a[k]    = r_a[k-1];
            assign w_b[k]    = r_b[k-1];
            assign w_sum[k]  = r_sum[k-1];
            assign w_cin[k]  = r_ctl[k-1].carry;
            assign w_mode[k] = r_ctl[k-1].mode;
            assign w_vld[k]  = r_ctl[k-1].valid;
        end

        adder_slice_ripple #(
            .SLICE (SLICE)
        ) u_slice (
            .i_a    (w_a[k][k*SLICE +: SLICE]),
            .i_b    (w_b[k][k*SLICE +: SLICE]),
            .i_cin  (w_cin[k]),
            .o_sum  (w_ssum[k]),
            .o_cout (w_cout[k]),
            .o_cim  (w_cim[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
                r_ctl[k] <= '0;
            end
        end else if (w_en) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                r_a[k]                     <= w_a[k];
                r_b[k]                     <= w_b[k];
                r_sum[k]                   <= w_sum[k];
                r_sum[k][k*SLICE +: SLICE] <= w_ssum[k];
                r_ctl[k].valid             <= w_vld[k];
                r_ctl[k].mode              <= w_mode[k];
                r_ctl[k].carry             <= w_cout[k];
                r_ctl[k].cim               <= w_cim[k];
            end
        end
    end

    assign bus.out_valid = r_ctl[LAST].valid;
    assign bus.sum       = r_sum[LAST];
    assign bus.overflow  = ovf_flag(r_ctl[LAST].mode, r_ctl[LAST].carry, r_ctl[LAST].cim);

    // The last stage's operand copies have no further consumer.
    assign w_unused_ok = ^{r_a[LAST], r_b[LAST]};
endmodule

// File: tb/tb_adder_nbit_pipelined.sv
// Directed bench for the pipelined adder in three configurations: 16/4, 16/1 and 8/2.
module tb_adder_nbit_pipelined;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adder_nbit_pipelined_if #(.NUM_BITS(16)) ifa ();
    adder_nbit_pipelined_if #(.NUM_BITS(16)) ifb ();
    adder_nbit_pipelined_if #(.NUM_BITS(8))  ifc ();

    adder_nbit_pipelined #(.NUM_BITS(16), .NUM_STAGES(4)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
    adder_nbit_pipelined #(.NUM_BITS(16), .NUM_STAGES(1)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));
    adder_nbit_pipelined #(.NUM_BITS(8),  .NUM_STAGES(2)) u_dut_c (.clk(clk), .rst(rst), .bus(ifc));

    typedef struct { logic [15:0] s; logic o; } exp_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   lat_acc;
    logic lat_on = 1'b0;
    exp_t q[$];

    logic [15:0] sa[10] = '{16'h1234, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0F0F,
                            16'hA5A5, 16'h0001, 16'hC000, 16'h4000, 16'hFF00};
    logic [15:0] sb[10] = '{16'h4321, 16'h8000, 16'hFFFF, 16'h7FFF, 16'hF0F0,
                            16'h5A5A, 16'hFFFF, 16'hC000, 16'h4000, 16'h0100};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model16(input logic [15:0] a, input logic [15:0] b,
                                     input logic cin, input logic m);
        logic [16:0] t;
        exp_t        e;
        t   = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        e.s = t[15:0];
        e.o = m ? ((a[15] == b[15]) && (t[15] != a[15])) : t[16];
        return e;
    endfunction

    task automatic step_a(input logic v, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic m, input logic rdy,
                          input exp_t e, output logic acc);
        @(negedge clk);
        ifa.in_valid    = v;
        ifa.a           = a;
        ifa.b           = b;
        ifa.carry_in    = cin;
        ifa.signed_mode = m;
        ifa.out_ready   = rdy;
        #1;
        if (ifa.out_valid) begin
            if (lat_on) begin
                chk("latency_a", cyc - lat_acc, 4);
                lat_on = 1'b0;
            end
            if (ifa.out_ready) begin
                if (q.size() == 0) begin
                    chk("stale_out_a", {31'd0, ifa.out_valid}, 32'd0);
                end else begin
                    exp_t x;
                    x = q.pop_front();
                    chk("sum_a", {16'd0, ifa.sum}, {16'd0, x.s});
                    chk("ovf_a", {31'd0, ifa.overflow}, {31'd0, x.o});
                end
            end
        end
        acc = v && ifa.in_ready;
        if (acc) q.push_back(e);
        cyc++;
    endtask

    task automatic idle_a(input int n);
        logic acc;
        exp_t z;
        z = '{16'd0, 1'b0};
        repeat (n) step_a(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, z, acc);
    endtask

    task automatic drain_a(output int k);
        k = 0;
        while (q.size() > 0 && k < 50) begin
            idle_a(1);
            k++;
        end
        if (q.size() != 0) chk("drain_timeout_a", q.size(), 0);
    endtask

    task automatic beat_a(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic m, input logic [15:0] es, input logic eo);
        logic acc;
        int   k;
        lat_acc = cyc;
        lat_on  = 1'b1;
        step_a(1'b1, a, b, cin, m, 1'b1, '{es, eo}, acc);
        chk("accept_a", {31'd0, acc}, 32'd1);
        drain_a(k);
    endtask

    task automatic beat_b(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic m, input logic [15:0] es, input logic eo);
        int k;
        @(negedge clk);
        ifb.in_valid = 1'b1; ifb.a = a; ifb.b = b; ifb.carry_in = cin; ifb.signed_mode = m;
        #1;
        chk("accept_b", {31'd0, ifb.in_ready}, 32'd1);
        k = 0;
        do begin
            @(negedge clk);
            ifb.in_valid = 1'b0;
            k++;
            #1;
        end while (!ifb.out_valid && k < 10);
        chk("latency_b", k, 1);
        chk("sum_b", {16'd0, ifb.sum}, {16'd0, es});
        chk("ovf_b", {31'd0, ifb.overflow}, {31'd0, eo});
    endtask

    task automatic beat_c(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic m, input logic [7:0] es, input logic eo);
        int k;
        @(negedge clk);
        ifc.in_valid = 1'b1; ifc.a = a; ifc.b = b; ifc.carry_in = cin; ifc.signed_mode = m;
        #1;
        chk("accept_c", {31'd0, ifc.in_ready}, 32'd1);
        k = 0;
        do begin
            @(negedge clk);
            ifc.in_valid = 1'b0;
            k++;
            #1;
        end while (!ifc.out_valid && k < 10);
        chk("latency_c", k, 2);
        chk("sum_c", {24'd0, ifc.sum}, {24'd0, es});
        chk("ovf_c", {31'd0, ifc.overflow}, {31'd0, eo});
    endtask

    task automatic reset_check;
        @(negedge clk);
        rst = 1'b1;
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_vld", {31'd0, ifa.out_valid}, 32'd0);
        chk("rst_sum", {16'd0, ifa.sum}, 32'd0);
        chk("rst_ovf", {31'd0, ifa.overflow}, 32'd0);
        chk("rst_rdy", {31'd0, ifa.in_ready}, 32'd1);
        q.delete();
        lat_on = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic acc;
        int   k;
        int   i;
        exp_t e;

        ifa.in_valid = 1'b0; ifa.a = '0; ifa.b = '0; ifa.carry_in = 1'b0;
        ifa.signed_mode = 1'b0; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.a = '0; ifb.b = '0; ifb.carry_in = 1'b0;
        ifb.signed_mode = 1'b0; ifb.out_ready = 1'b1;
        ifc.in_valid = 1'b0; ifc.a = '0; ifc.b = '0; ifc.carry_in = 1'b0;
        ifc.signed_mode = 1'b0; ifc.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset_check();

        beat_a(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
        beat_a(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1);
        beat_a(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0);
        beat_a(16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0);
        beat_a(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
        beat_a(16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1);
        beat_a(16'h8000, 16'hFFFF, 1'b0, 1'b1, 16'h7FFF, 1'b1);
        beat_a(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 1'b0);

        // back-to-back stream with alternating overflow mode
        for (i = 0; i < 10; i++) begin
            e = model16(sa[i], sb[i], i[1], i[0]);
            step_a(1'b1, sa[i], sb[i], i[1], i[0], 1'b1, e, acc);
            chk("stream_acc", {31'd0, acc}, 32'd1);
        end
        drain_a(k);
        chk("stream_drain", k, 4);

        // stall the consumer with a full pipeline and a pending producer beat
        for (i = 0; i < 6; i++) begin
            e = model16(sa[i], sb[9-i], i[0], ~i[0]);
            step_a(1'b1, sa[i], sb[9-i], i[0], ~i[0], 1'b1, e, acc);
        end
        i = 6;
        e = model16(sa[i], sb[9-i], i[0], ~i[0]);
        repeat (3) begin
            step_a(1'b1, sa[i], sb[9-i], i[0], ~i[0], 1'b0, e, acc);
            chk("stall_acc", {31'd0, acc}, 32'd0);
            chk("stall_rdy", {31'd0, ifa.in_ready}, 32'd0);
            chk("stall_head", {15'd0, ifa.overflow, ifa.sum}, {15'd0, q[0].o, q[0].s});
        end
        k = 0;
        while (i < 10 && k < 40) begin
            e = model16(sa[i], sb[9-i], i[0], ~i[0]);
            step_a(1'b1, sa[i], sb[9-i], i[0], ~i[0], 1'b1, e, acc);
            if (acc) i++;
            k++;
        end
        chk("stall_resume", i, 10);
        drain_a(k);

        // reset with three beats in flight
        for (i = 0; i < 3; i++) begin
            e = model16(sa[i], sb[i], 1'b0, 1'b0);
            step_a(1'b1, sa[i], sb[i], 1'b0, 1'b0, 1'b1, e, acc);
        end
        reset_check();
        ifa.out_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            #1;
            chk("post_rst_vld", {31'd0, ifa.out_valid}, 32'd0);
        end

        beat_b(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
        beat_b(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1);
        beat_c(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        beat_c(8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 1'b1);
        beat_c(8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
